// File: rtl/fanout_fork_pkg.sv
// Shared types and constants for the eager-fork controller.
// The optional stall counter in fanout_fork_ctrl is enabled by FANOUT_FORK_STATS_EN.
package fanout_fork_pkg;

  localparam int unsigned FANOUT_DEFAULT_NUM_OUT = 6;
  localparam int unsigned STALL_CNT_WIDTH        = 32;

  typedef enum logic {
    IDLE,
    PARTIAL
  } fork_state_t;

  // Branch is satisfied for the current token if disabled, already done, or accepting now.
  function automatic logic branch_satisfied(input logic en, input logic done, input logic acc);
    return ~en | done | acc;
  endfunction

endpackage

// File: rtl/fanout_fork_stats.sv
// Saturating stall-cycle counter for the fanout fork; cleared by synchronous reset.
// Only instantiated when FANOUT_FORK_STATS_EN is defined.
module fanout_fork_stats
  import fanout_fork_pkg::*;
#(
  parameter int unsigned WIDTH = STALL_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (stall && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Eager-fork controller: one ready/valid producer to NUM_OUT consumers with per-branch acceptance.
// Define FANOUT_FORK_STATS_EN to add the saturating stall_cycles output.
module fanout_fork_ctrl
  import fanout_fork_pkg::*;
#(
  parameter int unsigned NUM_OUT    = FANOUT_DEFAULT_NUM_OUT,
  parameter int unsigned DATA_WIDTH = 17
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic [NUM_OUT-1:0]            cfg_out_en,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready
`ifdef FANOUT_FORK_STATS_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0]    stall_cycles
`endif
);

  fork_state_t state_q, state_d;
  logic [NUM_OUT-1:0] done_q, done_d;
  logic [NUM_OUT-1:0] held_q, held_d;

  logic [NUM_OUT-1:0] eff_mask;
  logic [NUM_OUT-1:0] acc;
  logic [NUM_OUT-1:0] satisfied;
  logic               active;
  logic               complete;

  // Mask is frozen once a token is partially delivered so config changes never split a token.
  assign eff_mask = (state_q == PARTIAL) ? held_q : cfg_out_en;
  assign active   = clk_en & ~reset;

  always_comb begin
    out_valid = '0;
    acc       = '0;
    satisfied = '0;
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      out_valid[i] = active & in_valid & eff_mask[i] & ~done_q[i];
      acc[i]       = out_valid[i] & out_ready[i];
      satisfied[i] = branch_satisfied(eff_mask[i], done_q[i], acc[i]);
    end
  end

  assign complete = &satisfied;
  assign in_ready = active & complete;
  assign out_data = {NUM_OUT{in_data}};

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    held_d  = held_q;
    if (in_valid && in_ready) begin
      done_d  = '0;
      state_d = IDLE;
    end else if (clk_en) begin
      done_d  = done_q | acc;
      state_d = (|done_d) ? PARTIAL : IDLE;
      if (state_q == IDLE && state_d == PARTIAL) begin
        held_d = cfg_out_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      held_q  <= held_d;
    end
  end

`ifdef FANOUT_FORK_STATS_EN
  fanout_fork_stats #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stats (
    .clk   (clk),
    .reset (reset),
    .stall (clk_en & in_valid & ~in_ready),
    .count (stall_cycles)
  );
`endif

  no_dup_accept: assert property (@(posedge clk) disable iff (reset)
    (acc & done_q) == '0);

  in_valid_stable: assert property (@(posedge clk) disable iff (reset)
    (state_q == PARTIAL) |-> in_valid);

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed self-checking bench for fanout_fork_ctrl; stall counter checks follow
// FANOUT_FORK_STATS_EN.
module tb_fanout_fork_ctrl;

  localparam int unsigned NOUT = 6;
  localparam int unsigned DW   = 17;

  logic               clk;
  logic               reset;
  logic               clk_en;
  logic [NOUT-1:0]    cfg_out_en;
  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [NOUT*DW-1:0] out_data;
  logic [NOUT-1:0]    out_valid;
  logic [NOUT-1:0]    out_ready;
`ifdef FANOUT_FORK_STATS_EN
  logic [31:0]        stall_cycles;
`endif

  int n_checks;
  int n_fail;
  int acc_cnt [NOUT];

  fanout_fork_ctrl #(
    .NUM_OUT    (NOUT),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .cfg_out_en (cfg_out_en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FANOUT_FORK_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_acc();
    for (int i = 0; i < int'(NOUT); i++) begin
      if (out_valid[i] && out_ready[i]) acc_cnt[i]++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    clk_en     = 1'b1;
    cfg_out_en = 6'b111111;
    in_data    = '0;
    in_valid   = 1'b1;
    out_ready  = 6'b111111;
    for (int i = 0; i < int'(NOUT); i++) acc_cnt[i] = 0;

    // Reset holds outputs low
    @(negedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    tick();

    // All enabled branches ready: one token per cycle
    cfg_out_en = 6'b000111;
    out_ready  = 6'b111111;
    in_valid   = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      in_data = DW'(t);
      #1;
      chk("burst_in_ready", 64'(in_ready), 64'd1);
      chk("burst_out_valid", 64'(out_valid), 64'b000111);
      chk("burst_data_b2", 64'(out_data[2*DW +: DW]), 64'(t));
      count_acc();
      tick();
    end
    chk("burst_cnt_b0", 64'(acc_cnt[0]), 64'd4);
    chk("burst_cnt_b2", 64'(acc_cnt[2]), 64'd4);
    chk("burst_cnt_b3", 64'(acc_cnt[3]), 64'd0);
    chk("burst_cnt_b5", 64'(acc_cnt[5]), 64'd0);

    // Staggered acceptance: branch 0 at cycle 0, branch 1 at cycle 3
    for (int i = 0; i < int'(NOUT); i++) acc_cnt[i] = 0;
    cfg_out_en = 6'b000011;
    in_data    = 17'h000AA;
    out_ready  = 6'b000001;
    #1;
    chk("stag_c0_out_valid", 64'(out_valid), 64'b000011);
    chk("stag_c0_in_ready", 64'(in_ready), 64'd0);
    chk("stag_c0_data_b0", 64'(out_data[0 +: DW]), 64'h000AA);
    count_acc();
    tick();
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk("stag_mid_out_valid", 64'(out_valid), 64'b000010);
      chk("stag_mid_in_ready", 64'(in_ready), 64'd0);
      count_acc();
      tick();
    end
    out_ready = 6'b000011;
    #1;
    chk("stag_c3_out_valid", 64'(out_valid), 64'b000010);
    chk("stag_c3_in_ready", 64'(in_ready), 64'd1);
    count_acc();
    tick();
    chk("stag_b0_once", 64'(acc_cnt[0]), 64'd1);
    chk("stag_b1_once", 64'(acc_cnt[1]), 64'd1);
    // Next token is offered to both branches again
    in_data   = 17'h000BB;
    out_ready = 6'b000000;
    #1;
    chk("stag_next_out_valid", 64'(out_valid), 64'b000011);
    chk("stag_next_in_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 6'b000011;
    #1;
    chk("stag_next_drain", 64'(in_ready), 64'd1);
    tick();

    // Drop mode: nothing enabled, producer drained
    cfg_out_en = 6'b000000;
    out_ready  = 6'b101010;
    for (int t = 0; t < 5; t++) begin
      in_data = DW'(16'h0100 + t);
      #1;
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      chk("drop_out_valid", 64'(out_valid), 64'd0);
      tick();
    end

    // Config change while PARTIAL does not affect in-flight token
    cfg_out_en = 6'b000011;
    in_data    = 17'h000CC;
    out_ready  = 6'b000001;
    #1;
    chk("cfg_c0_in_ready", 64'(in_ready), 64'd0);
    tick();
    cfg_out_en = 6'b111111;
    out_ready  = 6'b000000;
    #1;
    chk("cfg_held_out_valid", 64'(out_valid), 64'b000010);
    tick();
    out_ready = 6'b111111;
    #1;
    chk("cfg_held_finish_valid", 64'(out_valid), 64'b000010);
    chk("cfg_held_finish_ready", 64'(in_ready), 64'd1);
    tick();
    in_data = 17'h000DD;
    #1;
    chk("cfg_new_out_valid", 64'(out_valid), 64'b111111);
    chk("cfg_new_in_ready", 64'(in_ready), 64'd1);
    tick();

    // clk_en low freezes state and forces outputs low
    cfg_out_en = 6'b000011;
    in_data    = 17'h000EE;
    out_ready  = 6'b000001;
    #1;
    chk("clken_c0_in_ready", 64'(in_ready), 64'd0);
    tick();
    clk_en    = 1'b0;
    out_ready = 6'b111111;
    #1;
    chk("clken_low_out_valid", 64'(out_valid), 64'd0);
    chk("clken_low_in_ready", 64'(in_ready), 64'd0);
    tick();
    clk_en    = 1'b1;
    out_ready = 6'b000000;
    #1;
    chk("clken_resume_valid", 64'(out_valid), 64'b000010);
    tick();

    // Reset mid-token flushes done; token re-offered to both branches
    reset = 1'b1;
    #1;
    chk("flush_rst_out_valid", 64'(out_valid), 64'd0);
    chk("flush_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("flush_out_valid", 64'(out_valid), 64'b000011);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
`ifdef FANOUT_FORK_STATS_EN
      chk("stats_counting", 64'(stall_cycles), 64'(c));
`endif
      tick();
    end
    out_ready = 6'b000011;
    #1;
    chk("flush_drain", 64'(in_ready), 64'd1);
`ifdef FANOUT_FORK_STATS_EN
    chk("stats_three", 64'(stall_cycles), 64'd3);
`endif
    tick();
    in_valid = 1'b0;
    #1;
    chk("final_out_valid", 64'(out_valid), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
